// File: rtl/delay_line_prog.sv
// delay_line_prog: runtime-programmable valid/data delay line that advances on en and flushes on depth change.
// Define DELAY_LINE_PROG_INFLIGHT_EN to add the inflight_o token counter.
module delay_line_prog #(
    parameter int WIDTH         = 16,
    parameter int MAX_DEPTH     = 32,
    parameter int DEFAULT_DEPTH = MAX_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       depth_load,
    input  logic [$clog2(MAX_DEPTH):0] depth_i,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic                       filled_o,
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
    output logic [$clog2(MAX_DEPTH):0] depth_o,
    output logic [$clog2(MAX_DEPTH):0] inflight_o
`else
    output logic [$clog2(MAX_DEPTH):0] depth_o
`endif
);
    localparam int PW = $clog2(MAX_DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] RST_D = DEFAULT_DEPTH < 1 ? DW'(1) :
                                      DEFAULT_DEPTH > MAX_DEPTH ? MAX_D : DW'(DEFAULT_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(MAX_DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        depth_q, depth_d, cnt_q, cnt_d, load_val, rd_sum;
    logic [PW-1:0]        wp_q, wp_d, rd_ptr;
    logic [MAX_DEPTH-1:0] vmem_q, vmem_d;
    logic [WIDTH-1:0]     dmem_q [MAX_DEPTH];
    logic [WIDTH-1:0]     dmem_d [MAX_DEPTH];
    logic                 valid_q, valid_d, rd_valid;
    logic [WIDTH-1:0]     data_q, data_d, rd_data;

    // The output register is the last stage, so the buffer only holds D-1 entries
    // and a depth of 1 bypasses the buffer entirely.
    always_comb begin
        load_val = depth_i == '0 ? DW'(1) : depth_i > MAX_D ? MAX_D : depth_i;
        rd_sum   = DW'(wp_q) + MAX_D - (depth_q - DW'(1));
        rd_ptr   = PW'(rd_sum >= MAX_D ? rd_sum - MAX_D : rd_sum);
        rd_valid = depth_q == DW'(1) ? valid_i : vmem_q[rd_ptr];
        rd_data  = depth_q == DW'(1) ? data_i : dmem_q[rd_ptr];
        depth_d  = depth_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        wp_d     = wp_q;
        vmem_d   = vmem_q;
        dmem_d   = dmem_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (depth_load) begin
            depth_d = load_val;
            state_d = EMPTY;
            cnt_d   = '0;
            wp_d    = '0;
            vmem_d  = '0;
            valid_d = 1'b0;
            data_d  = '0;
        end else if (en) begin
            vmem_d[wp_q] = valid_i;
            dmem_d[wp_q] = data_i;
            wp_d         = wp_q == LAST ? '0 : wp_q + PW'(1);
            valid_d      = rd_valid;
            data_d       = rd_valid ? rd_data : '0;
            cnt_d        = state_q == FULL ? cnt_q : cnt_q + DW'(1);
            state_d      = state_q == FULL || cnt_d == depth_q ? FULL : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= RST_D;
            state_q <= EMPTY;
            cnt_q   <= '0;
            wp_q    <= '0;
            vmem_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            depth_q <= depth_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            vmem_q  <= vmem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        dmem_q <= dmem_d;
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign filled_o = state_q == FULL;
    assign depth_o  = depth_q;

`ifdef DELAY_LINE_PROG_INFLIGHT_EN
    logic [DW-1:0] infl_q, infl_d;

    always_comb begin
        infl_d = depth_load ? '0 : en ? infl_q + DW'(valid_i) - DW'(rd_valid) : infl_q;
    end

    always_ff @(posedge clk) begin
        infl_q <= reset ? '0 : infl_d;
    end

    assign inflight_o = infl_q;
`else
    // Without the counter the line has no per-token bookkeeping beyond the valid bits.
`endif
endmodule

// File: tb/tb_delay_line_prog.sv
// tb_delay_line_prog: directed checks of delay, en gating, flush, clamp and pointer wrap.
module tb_delay_line_prog;
    localparam int W  = 16;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset, en, depth_load, valid_i;
    logic [DW-1:0] depth_i;
    logic [W-1:0]  data_i;
    logic          valid_o, filled_o;
    logic [W-1:0]  data_o;
    logic [DW-1:0] depth_o;
    logic          en2, valid2_i, depth_load2;
    logic [DW-1:0] depth2_i;
    logic [W-1:0]  data2_i;
    logic          valid2_o, filled2_o;
    logic [W-1:0]  data2_o;
    logic [DW-1:0] depth2_o;
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
    logic [DW-1:0] inflight_o, inflight2_o;
`endif
    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    delay_line_prog #(.WIDTH(W), .MAX_DEPTH(32), .DEFAULT_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .depth_load(depth_load), .depth_i(depth_i),
        .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o), .data_o(data_o),
        .filled_o(filled_o), .depth_o(depth_o)
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        , .inflight_o(inflight_o)
`endif
    );

    delay_line_prog #(.WIDTH(W), .MAX_DEPTH(20), .DEFAULT_DEPTH(20)) dut20 (
        .clk(clk), .reset(reset), .en(en2), .depth_load(depth_load2), .depth_i(depth2_i),
        .valid_i(valid2_i), .data_i(data2_i), .valid_o(valid2_o), .data_o(data2_o),
        .filled_o(filled2_o), .depth_o(depth2_o)
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        , .inflight_o(inflight2_o)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_depth(input int d);
        depth_load = 1'b1;
        depth_i    = DW'(d);
        en         = 1'b0;
        tick();
        depth_load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; depth_load = 1'b0; depth_i = '0; valid_i = 1'b0; data_i = '0;
        en2 = 1'b0; depth_load2 = 1'b0; depth2_i = '0; valid2_i = 1'b0; data2_i = '0;
        tick();
        tick();
        reset = 1'b0;
        n_run++;
        if ({valid_o, data_o, filled_o, depth_o} !== {1'b0, 16'h0, 1'b0, 6'd32}) begin
            n_fail++;
            $display("FAIL reset: got v=%b d=%h f=%b D=%0d, want v=0 d=0000 f=0 D=32", valid_o, data_o, filled_o, depth_o);
        end
        n_run++;
        if ({valid2_o, filled2_o, depth2_o} !== {1'b0, 1'b0, 6'd20}) begin
            n_fail++;
            $display("FAIL reset20: got v=%b f=%b D=%0d, want v=0 f=0 D=20", valid2_o, filled2_o, depth2_o);
        end
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        n_run++;
        if (inflight_o !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_inflight: got %0d, want 0", inflight_o);
        end
`endif
    endtask

    task automatic test_default_depth;
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            valid_i = k == 1;
            data_i  = k == 1 ? 16'hA5A5 : 16'hFFFF;
            tick();
            n_run++;
            if ({valid_o, data_o, filled_o} !== {k == 32, k == 32 ? 16'hA5A5 : 16'h0, k >= 32}) begin
                n_fail++;
                $display("FAIL default_d32 cycle %0d: got v=%b d=%h f=%b, want v=%b d=%h f=%b", k,
                         valid_o, data_o, filled_o, k == 32, k == 32 ? 16'hA5A5 : 16'h0, k >= 32);
            end
        end
        en = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_depth_one;
        depth_load = 1'b1; depth_i = 6'd1; en = 1'b1; valid_i = 1'b1; data_i = 16'hDEAD;
        tick();
        depth_load = 1'b0;
        n_run++;
        if ({valid_o, data_o, filled_o, depth_o} !== {1'b0, 16'h0, 1'b0, 6'd1}) begin
            n_fail++;
            $display("FAIL d1_load: got v=%b d=%h f=%b D=%0d, want v=0 d=0000 f=0 D=1", valid_o, data_o, filled_o, depth_o);
        end
        for (int k = 1; k <= 4; k++) begin
            valid_i = k <= 3;
            data_i  = 16'(k);
            tick();
            n_run++;
            if ({valid_o, data_o, filled_o} !== {k <= 3, k <= 3 ? 16'(k) : 16'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL d1_stream %0d: got v=%b d=%h f=%b, want v=%b d=%h f=1", k,
                         valid_o, data_o, filled_o, k <= 3, k <= 3 ? 16'(k) : 16'h0);
            end
        end
        en = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_en_gating;
        int ens[8] = '{1, 0, 1, 1, 0, 1, 0, 1};
        int steps = 0;
        load_depth(4);
        for (int i = 0; i < 8; i++) begin
            en      = ens[i][0];
            valid_i = i == 0;
            data_i  = i == 0 ? 16'h1234 : 16'h5555;
            steps  += ens[i];
            tick();
            n_run++;
            if ({valid_o, data_o, filled_o} !== {steps == 4, steps == 4 ? 16'h1234 : 16'h0, steps >= 4}) begin
                n_fail++;
                $display("FAIL en_gating %0d: got v=%b d=%h f=%b, want v=%b d=%h f=%b", i, valid_o, data_o,
                         filled_o, steps == 4, steps == 4 ? 16'h1234 : 16'h0, steps >= 4);
            end
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
            n_run++;
            if (inflight_o !== DW'(steps < 4)) begin
                n_fail++;
                $display("FAIL en_gating_inflight %0d: got %0d, want %0d", i, inflight_o, steps < 4);
            end
`endif
        end
        en = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_flush;
        load_depth(8);
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; valid_i = 1'b1; data_i = 16'h100 + 16'(i);
            tick();
            n_run++;
            if (valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_fill %0d: got v=%b, want v=0", i, valid_o);
            end
        end
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        n_run++;
        if (inflight_o !== 6'd5) begin
            n_fail++;
            $display("FAIL flush_inflight_pre: got %0d, want 5", inflight_o);
        end
`endif
        depth_load = 1'b1; depth_i = 6'd3; valid_i = 1'b1; data_i = 16'h0BAD;
        tick();
        depth_load = 1'b0;
        n_run++;
        if ({valid_o, data_o, filled_o, depth_o} !== {1'b0, 16'h0, 1'b0, 6'd3}) begin
            n_fail++;
            $display("FAIL flush_load: got v=%b d=%h f=%b D=%0d, want v=0 d=0000 f=0 D=3", valid_o, data_o, filled_o, depth_o);
        end
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        n_run++;
        if (inflight_o !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_inflight_post: got %0d, want 0", inflight_o);
        end
`endif
        for (int j = 1; j <= 12; j++) begin
            valid_i = j == 1;
            data_i  = j == 1 ? 16'h0300 : 16'h0;
            tick();
            n_run++;
            if ({valid_o, data_o, filled_o} !== {j == 3, j == 3 ? 16'h0300 : 16'h0, j >= 3}) begin
                n_fail++;
                $display("FAIL flush_new %0d: got v=%b d=%h f=%b, want v=%b d=%h f=%b", j, valid_o, data_o,
                         filled_o, j == 3, j == 3 ? 16'h0300 : 16'h0, j >= 3);
            end
        end
        en = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_clamp;
        int ins[6]  = '{0, 1, 32, 33, 40, 63};
        int exps[6] = '{1, 1, 32, 32, 32, 32};
        for (int i = 0; i < 6; i++) begin
            load_depth(ins[i]);
            n_run++;
            if (depth_o !== DW'(exps[i])) begin
                n_fail++;
                $display("FAIL clamp depth_i=%0d: got %0d, want %0d", ins[i], depth_o, exps[i]);
            end
        end
    endtask

    task automatic test_wrap20;
        logic [W:0] hist[121];
        logic [W:0] want;
        en2 = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            valid2_i = k <= 100 && (k % 3) != 0;
            data2_i  = 16'(k * 7 + 1);
            hist[k]  = {valid2_i, valid2_i ? data2_i : 16'h0};
            tick();
            want = k >= 20 ? hist[k - 19] : '0;
            n_run++;
            if ({valid2_o, data2_o, filled2_o} !== {want, k >= 20}) begin
                n_fail++;
                $display("FAIL wrap20 cycle %0d: got v=%b d=%h f=%b, want v=%b d=%h f=%b", k, valid2_o,
                         data2_o, filled2_o, want[W], want[W-1:0], k >= 20);
            end
        end
        en2 = 1'b0; valid2_i = 1'b0;
    endtask

    task automatic test_reset_midstream;
        load_depth(5);
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; valid_i = 1'b1; data_i = 16'h50 + 16'(i);
            tick();
        end
        n_run++;
        if ({valid_o, data_o, filled_o} !== {1'b1, 16'h51, 1'b1}) begin
            n_fail++;
            $display("FAIL midstream_pre: got v=%b d=%h f=%b, want v=1 d=0051 f=1", valid_o, data_o, filled_o);
        end
        reset = 1'b1; depth_load = 1'b1; depth_i = 6'd3; valid_i = 1'b1; data_i = 16'h77;
        tick();
        reset = 1'b0; depth_load = 1'b0; valid_i = 1'b0;
        n_run++;
        if ({valid_o, data_o, filled_o, depth_o} !== {1'b0, 16'h0, 1'b0, 6'd32}) begin
            n_fail++;
            $display("FAIL midstream_reset: got v=%b d=%h f=%b D=%0d, want v=0 d=0000 f=0 D=32", valid_o, data_o, filled_o, depth_o);
        end
`ifdef DELAY_LINE_PROG_INFLIGHT_EN
        n_run++;
        if (inflight_o !== 6'd0) begin
            n_fail++;
            $display("FAIL midstream_inflight: got %0d, want 0", inflight_o);
        end
`endif
        for (int k = 1; k <= 34; k++) begin
            tick();
            n_run++;
            if ({valid_o, filled_o} !== {1'b0, k >= 32}) begin
                n_fail++;
                $display("FAIL midstream_drain %0d: got v=%b f=%b, want v=0 f=%b", k, valid_o, filled_o, k >= 32);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_depth();
        test_depth_one();
        test_en_gating();
        test_flush();
        test_clamp();
        test_wrap20();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/delay_line_prog.md
# delay_line_prog

Parametrised, runtime-programmable delay line for the valid/data sideband of the NTT datapath. It replaces fixed-stage shift registers wherever a unit's latency depends on configuration, such as butterfly depth or modulus mode. Data advances only on enabled cycles, so the delay is counted in pipeline steps rather than clock cycles. A depth change flushes the line cleanly, and a fill state machine reports when the line has reached its configured latency.

## Interface
Parameters:
- WIDTH, 16, data bits per entry
- MAX_DEPTH, 32, maximum delay in enabled cycles; must be ≥ 2
- DEFAULT_DEPTH, MAX_DEPTH, depth loaded at reset; range 1..MAX_DEPTH

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  advance enable; 0 = hold the entire state
- depth_load  in  1  single-cycle strobe; latch depth_i and flush the line
- depth_i  in  $clog2(MAX_DEPTH)+1  requested delay
- valid_i  in  1  input valid
- data_i  in  WIDTH  input data
- valid_o  out  1  valid delayed by D enabled cycles
- data_o  out  WIDTH  data delayed by D enabled cycles; 0 whenever valid_o=0
- filled_o  out  1  line holds D entries since the last flush
- depth_o  out  $clog2(MAX_DEPTH)+1  currently active depth D

## Operation
- Circular buffer of MAX_DEPTH entries, each {valid, data}, with a write pointer.
  - Read position is the write pointer minus D, modulo MAX_DEPTH.
  - Pointers wrap at MAX_DEPTH, including non-power-of-2 values.
- Behavioural contract:
  - The output after enabled step n equals the input sampled at enabled step n−D.
  - Steps before the fill is complete output valid=0, data=0.
- Depth clamp on load:
  - depth_i=0 loads 1.
  - depth_i > MAX_DEPTH loads MAX_DEPTH.
- Flush, caused by reset or depth_load:
  - Clears all entry valid bits and the fill counter.
  - Forces valid_o=0 and data_o=0.
  - Stored data bits need not be cleared.
- Fill FSM:
  - EMPTY → FILL on the first enabled cycle, or → FULL directly if D=1.
  - FILL: the fill counter increments per enabled cycle; → FULL when the counter reaches D.
  - FULL: holds until the next flush; filled_o=1 only in FULL.
- Priority: reset > depth_load > en.
  - With depth_load and en in the same cycle, the input sample is discarded.
- en=0: pointers, FSM, counters and outputs all hold their values.

## Timing
- Reset values:
  - valid_o=0, data_o=0, filled_o=0.
  - depth_o=DEFAULT_DEPTH (clamped), FSM=EMPTY.
- Outputs are registered.
  - With en held high, an input at cycle t appears at cycle t+D.
  - This is identical to a D-stage shift register.
- With en toggling, the delay is D enabled cycles, and outputs change only on cycles following en=1.
- depth_load at cycle t:
  - depth_o shows the new value at t+1.
  - valid_o=0 at t+1.
  - The first new-depth output is valid D enabled cycles after the first enabled cycle at or after t+1.
- No token accepted before a flush ever appears on valid_o after it.
- Reset mid-operation behaves like depth_load with DEFAULT_DEPTH. In-flight tokens are lost.

## Configuration
- Macro DELAY_LINE_PROG_INFLIGHT_EN.
- When defined:
  - Adds output port inflight_o [$clog2(MAX_DEPTH):0], the count of accepted valid_i=1 tokens not yet presented on valid_o.
  - Update on each enabled cycle: +valid_i, −(valid bit being shifted out toward valid_o).
  - Registered, aligned with valid_o.
  - Reset/flush → 0; never exceeds D.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, default D=32, en=1, valid_i=1 with data_i=0xA5A5 at cycle 0 only → valid_o=1, data_o=0xA5A5 at cycle 32 only; filled_o rises at cycle 32.
- Load depth_i=1, then stream values 1,2,3 with en=1 → data_o shows 1,2,3 one cycle later each; filled_o=1 after the first enabled cycle.
- D=4 with en pattern 1,0,1,1,0,1 and a valid token at the first enabled cycle → token appears after the 4th enabled cycle; outputs hold during en=0.
- D=8, tokens in flight, depth_load with depth_i=3 → valid_o=0 the next cycle; no old token emerges; new tokens delayed by 3; inflight_o (if enabled) drops to 0.
- Clamp: depth_i=0 → depth_o=1; depth_i=40 with MAX_DEPTH=32 → depth_o=32; MAX_DEPTH=20, D=20 → correct wrap over 100 cycles.
- Reset asserted mid-stream with depth_load and en also high → all outputs reach reset values next cycle; depth_o=DEFAULT_DEPTH.
